// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM state encoding and verdict codes.
package core_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ERR     = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

endpackage

// File: rtl/core_run_ctrl_irq_chan_timer.sv
// One interrupt channel: down-counting period timer with a sticky pending flag.
module irq_chan_timer #(
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             count_en,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  input  logic             ack,
  output logic             pending
);

  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cur;
  logic             active;
  logic             hit;

  // cnt==0 means "reload pending": the period is sampled only here, so a new
  // period value takes effect at the next reload.
  assign cur    = (cnt == '0) ? period : cnt;
  assign active = count_en && en && (period != '0);
  assign hit    = active && (cur == PER_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (active) begin
        cnt <= hit ? '0 : cur - 1'b1;
      end
      if (hit) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, optionally generates periodic interrupts
// (macro CORE_RUN_CTRL_IRQ_GEN_EN), and reports a pass/fail verdict per run.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// RESET | core_rst_n low for RST_CYCLES cycles
// RUN   | core running, cycle_count advancing, termination checks active
// DONE  | verdict held until the next start
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 8,
  parameter int IRQ_CH         = 4,
  parameter int PER_W          = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 300,
  parameter int WFI_SETTLE     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    pc_init_sel,
  input  logic [IRQ_CH-1:0]       irq_en,
  input  logic [IRQ_CH*PER_W-1:0] irq_period,
  input  logic [IRQ_CH-1:0]       irq_ack,
  input  logic                    core_wfi,
  input  logic                    core_unexcp_err,
  output logic                    core_rst_n,
  output logic                    pc_init_use,
  output logic                    extenal_interrupt,
  output logic [IRQ_CH-1:0]       irq_pending,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [1:0]              fail_code,
  output logic [CNT_W-1:0]        cycle_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SC_W = (WFI_SETTLE > 1) ? $clog2(WFI_SETTLE) : 1;

  run_state_t      state, next_state;
  logic [RC_W-1:0] rst_cnt;
  logic [SC_W-1:0] settle_cnt;
  logic            enter_reset;
  logic            terminate;
  logic            quiet;
  logic            settle_hit;
  logic            timeout_hit;

  assign quiet       = core_wfi && !extenal_interrupt;
  assign settle_hit  = quiet && (settle_cnt == SC_W'(WFI_SETTLE - 1));
  assign timeout_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    enter_reset = 1'b0;
    terminate   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state  = RESET;
          enter_reset = 1'b1;
        end
      end
      RESET: begin
        if (rst_cnt == '0) next_state = RUN;
      end
      RUN: begin
        if (core_unexcp_err || settle_hit || timeout_hit) begin
          next_state = DONE;
          terminate  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_cnt     <= '0;
      settle_cnt  <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      pc_init_use <= 1'b0;
    end else if (enter_reset) begin
      rst_cnt     <= RC_W'(RST_CYCLES - 1);
      settle_cnt  <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      pc_init_use <= pc_init_sel;
    end else if (state == RESET) begin
      if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
    end else if (state == RUN) begin
      if (terminate) begin
        // error outranks pass, pass outranks timeout
        pass      <= !core_unexcp_err && settle_hit;
        fail_code <= core_unexcp_err ? FAIL_ERR :
                     settle_hit      ? FAIL_NONE : FAIL_TIMEOUT;
      end else begin
        cycle_count <= cycle_count + 1'b1;
        settle_cnt  <= quiet ? settle_cnt + 1'b1 : '0;
      end
    end
  end

  assign core_rst_n = (state == RUN) || (state == DONE);
  assign busy       = (state == RESET) || (state == RUN);
  assign done       = (state == DONE);

`ifdef CORE_RUN_CTRL_IRQ_GEN_EN
  for (genvar i = 0; i < IRQ_CH; i++) begin : g_chan
    irq_chan_timer #(.PER_W(PER_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (enter_reset),
      .count_en (state == RUN),
      .en       (irq_en[i]),
      .period   (irq_period[i*PER_W +: PER_W]),
      .ack      (irq_ack[i]),
      .pending  (irq_pending[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || enter_reset) extenal_interrupt <= 1'b0;
    else                       extenal_interrupt <= |(irq_pending & irq_en);
  end
`else
  logic unused_irq;
  assign unused_irq        = ^{irq_en, irq_period, irq_ack};
  assign irq_pending       = '0;
  assign extenal_interrupt = 1'b0;
`endif

endmodule
